// File: rtl/lane_pipe_regs_pkg.sv
// lane_pipe_regs_pkg: shared defaults, stage-select encoding and output slot indexing
package lane_pipe_regs_pkg;
   localparam int PIPE_LANES  = 2;
   localparam int PIPE_STAGES = 4;
   localparam int PIPE_DATA_W = 64;
   typedef enum logic [1:0] {SEL_KEEP, SEL_LOAD, SEL_BUBBLE} stage_sel_e;
   function automatic int slot_lsb(input int stage, input int lane, input int lanes, input int data_w);
      return (stage * lanes + lane) * data_w;
   endfunction
endpackage

// File: rtl/lane_pipe_regs_pipe_stage_reg.sv
// pipe_stage_reg: one LANES-wide pipeline stage with load/keep/bubble select and per-lane pinning
module pipe_stage_reg
   import lane_pipe_regs_pkg::*;
#(
   parameter int LANES  = PIPE_LANES,
   parameter int DATA_W = PIPE_DATA_W
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  stage_sel_e              sel_i,
   input  logic [LANES-1:0]        keep_mask_i,
   input  logic [LANES-1:0]        valid_i,
   input  logic [LANES*DATA_W-1:0] data_i,
   output logic [LANES-1:0]        valid_o,
   output logic [LANES*DATA_W-1:0] data_o
);
   logic [LANES-1:0]        r_valid, w_valid_nxt;
   logic [LANES*DATA_W-1:0] r_data, w_data_nxt;
   // Bubble clears every lane; load takes the input except on pinned lanes; keep holds everything
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         w_valid_nxt[j] = (sel_i == SEL_BUBBLE) ? 1'b0 :
                          (sel_i == SEL_LOAD && !keep_mask_i[j]) ? valid_i[j] : r_valid[j];
         w_data_nxt[j*DATA_W +: DATA_W] = (sel_i == SEL_BUBBLE) ? {DATA_W{1'b0}} :
                          (sel_i == SEL_LOAD && !keep_mask_i[j]) ? data_i[j*DATA_W +: DATA_W] : r_data[j*DATA_W +: DATA_W];
      end
   end
   // Stage storage; reset empties the slot and zeroes its payload immediately
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
      end
   end
   assign valid_o = r_valid;
   assign data_o  = r_data;
endmodule

// File: rtl/lane_pipe_regs.sv
// lane_pipe_regs: multi-lane pipeline register array with bubble collapse, lane hold and depth flush
module lane_pipe_regs
   import lane_pipe_regs_pkg::*;
#(
   parameter int LANES  = PIPE_LANES,
   parameter int STAGES = PIPE_STAGES,
   parameter int DATA_W = PIPE_DATA_W,
   parameter int SW     = $clog2(STAGES)
) (
   input  logic                                clock_i,
   input  logic                                reset_i,
   input  logic [LANES-1:0]                    in_valid_i,
   input  logic [LANES*DATA_W-1:0]             in_data_i,
   output logic                                in_ready_o,
   input  logic [STAGES-1:0]                   stage_stall_i,
   input  logic [LANES-1:0]                    lane_hold_i,
   input  logic                                flush_i,
   input  logic [SW-1:0]                       flush_stage_i,
   output logic [STAGES*LANES-1:0]             valid_o,
   output logic [STAGES*LANES*DATA_W-1:0]      data_o,
   output logic [$clog2(STAGES*LANES+1)-1:0]   occupancy_o,
   output logic [15:0]                         stall_cnt_o
);
   localparam int OW = $clog2(STAGES*LANES+1);
   logic [LANES-1:0]        w_valid    [STAGES];
   logic [LANES*DATA_W-1:0] w_data     [STAGES];
   stage_sel_e              w_sel      [STAGES];
   logic [LANES-1:0]        w_keep     [STAGES];
   logic [LANES-1:0]        w_in_valid [STAGES];
   logic [LANES*DATA_W-1:0] w_in_data  [STAGES];
   logic [STAGES-1:0]       w_hold;
   logic [LANES-1:0]        w_lh_mask;
   logic                    w_lh_eff;
   int                      w_flush_k;
   logic [15:0]             r_stall_cnt;
   // Hold chain from the tail backwards: only occupied stages can stall, so empty stages collapse
   always_comb begin
      logic h;
      h = 1'b0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         h = (|w_valid[s]) & (stage_stall_i[s] | h);
         w_hold[s] = h;
      end
   end
   // Flush depth clamp, effective lane hold on occupied stage-0 lanes, and frontend ready
   always_comb begin
      w_flush_k  = (int'(flush_stage_i) >= STAGES) ? STAGES - 1 : int'(flush_stage_i);
      w_lh_mask  = lane_hold_i & w_valid[0];
      w_lh_eff   = !w_hold[0] && (|w_lh_mask);
      in_ready_o = !w_hold[0] && !w_lh_eff && !flush_i;
   end
   // Per-stage select: flush beats holds, then stall hold, then advance; held stage-0 lanes enter stage 1 as bubbles
   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         w_sel[s]      = SEL_LOAD;
         w_keep[s]     = '0;
         w_in_valid[s] = '0;
         w_in_data[s]  = '0;
      end
      if (flush_i) w_sel[0] = SEL_BUBBLE;
      else if (w_hold[0]) w_sel[0] = SEL_KEEP;
      w_keep[0]     = w_lh_eff ? w_lh_mask : '0;
      w_in_valid[0] = w_lh_eff ? '0 : in_valid_i;
      w_in_data[0]  = w_lh_eff ? '0 : in_data_i;
      for (int s = 1; s < STAGES; s++) begin
         if (flush_i && s <= w_flush_k) w_sel[s] = SEL_BUBBLE;
         else if (w_hold[s]) w_sel[s] = SEL_KEEP;
         else if ((flush_i && s == w_flush_k + 1) || w_hold[s-1]) w_sel[s] = SEL_BUBBLE;
         w_in_valid[s] = w_valid[s-1] & ~((s == 1) ? w_lh_mask : '0);
         for (int j = 0; j < LANES; j++)
            w_in_data[s][j*DATA_W +: DATA_W] = (s == 1 && w_lh_mask[j]) ? {DATA_W{1'b0}} : w_data[s-1][j*DATA_W +: DATA_W];
      end
   end
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      pipe_stage_reg #(.LANES(LANES), .DATA_W(DATA_W)) u_stage (
         .clock_i     (clock_i),
         .reset_i     (reset_i),
         .sel_i       (w_sel[s]),
         .keep_mask_i (w_keep[s]),
         .valid_i     (w_in_valid[s]),
         .data_i      (w_in_data[s]),
         .valid_o     (w_valid[s]),
         .data_o      (w_data[s])
      );
      assign valid_o[s*LANES +: LANES] = w_valid[s];
      assign data_o[slot_lsb(s, 0, LANES, DATA_W) +: LANES*DATA_W] = w_data[s];
   end
   // Population count of all registered lane valids
   always_comb begin
      occupancy_o = '0;
      for (int i = 0; i < STAGES*LANES; i++) occupancy_o = occupancy_o + OW'(valid_o[i]);
   end
   // Count cycles where the frontend offers work but stage 0 refuses it; stop at all-ones
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) r_stall_cnt <= '0;
      else if ((|in_valid_i) && !in_ready_o && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
   end
   assign stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_lane_pipe_regs.sv
// tb_lane_pipe_regs: directed scenario checks for lane_pipe_regs with LANES=2, STAGES=4, DATA_W=32
module tb_lane_pipe_regs;
   localparam int L = 2;
   localparam int S = 4;
   localparam int W = 32;
   logic            clock_i = 1'b0;
   logic            reset_i = 1'b1;
   logic [L-1:0]    in_valid_i = '0;
   logic [L*W-1:0]  in_data_i = '0;
   logic            in_ready_o;
   logic [S-1:0]    stage_stall_i = '0;
   logic [L-1:0]    lane_hold_i = '0;
   logic            flush_i = 1'b0;
   logic [1:0]      flush_stage_i = '0;
   logic [S*L-1:0]  valid_o;
   logic [S*L*W-1:0] data_o;
   logic [3:0]      occupancy_o;
   logic [15:0]     stall_cnt_o;
   int n_pass = 0;
   int n_tot  = 0;

   lane_pipe_regs #(.LANES(L), .STAGES(S), .DATA_W(W), .SW(2)) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .in_valid_i    (in_valid_i),
      .in_data_i     (in_data_i),
      .in_ready_o    (in_ready_o),
      .stage_stall_i (stage_stall_i),
      .lane_hold_i   (lane_hold_i),
      .flush_i       (flush_i),
      .flush_stage_i (flush_stage_i),
      .valid_o       (valid_o),
      .data_o        (data_o),
      .occupancy_o   (occupancy_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [W-1:0] dat(input int s, input int j);
      return data_o[(s*L+j)*W +: W];
   endfunction
   function automatic logic [L-1:0] vld(input int s);
      return valid_o[s*L +: L];
   endfunction

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic do_reset();
      in_valid_i = '0; in_data_i = '0; stage_stall_i = '0; lane_hold_i = '0;
      flush_i = 1'b0; flush_stage_i = '0;
      reset_i = 1'b1;
      repeat (2) @(posedge clock_i);
      #1 reset_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tot++; if (valid_o !== '0) $display("FAIL reset_valid got %h exp 0", valid_o); else n_pass++;
      n_tot++; if (data_o !== '0) $display("FAIL reset_data got nonzero exp 0"); else n_pass++;
      n_tot++; if (occupancy_o !== 4'd0) $display("FAIL reset_occ got %0d exp 0", occupancy_o); else n_pass++;
      n_tot++; if (stall_cnt_o !== 16'd0) $display("FAIL reset_stallcnt got %0d exp 0", stall_cnt_o); else n_pass++;
      n_tot++; if (in_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready_o); else n_pass++;
   endtask

   task automatic test_latency();
      do_reset();
      in_valid_i = 2'b11; in_data_i = {32'hB0, 32'hA0};
      repeat (3) tick();
      n_tot++; if (vld(3) !== 2'b00) $display("FAIL lat_early got %b exp 00", vld(3)); else n_pass++;
      tick();
      n_tot++; if (dat(3,0) !== 32'hA0) $display("FAIL lat_lane0 got %h exp a0", dat(3,0)); else n_pass++;
      n_tot++; if (dat(3,1) !== 32'hB0) $display("FAIL lat_lane1 got %h exp b0", dat(3,1)); else n_pass++;
      n_tot++; if (occupancy_o !== 4'd8) $display("FAIL lat_occ got %0d exp 8", occupancy_o); else n_pass++;
   endtask

   task automatic test_collapse();
      do_reset();
      in_valid_i = 2'b11; in_data_i = {32'h11, 32'h10}; tick();
      in_valid_i = 2'b00; tick();
      in_valid_i = 2'b11; in_data_i = {32'h13, 32'h12}; tick();
      in_valid_i = 2'b00; tick();
      n_tot++; if (valid_o !== 8'b11_00_11_00) $display("FAIL col_setup got %b exp 11001100", valid_o); else n_pass++;
      stage_stall_i = 4'b1000; in_valid_i = 2'b11; in_data_i = {32'h15, 32'h14}; tick();
      n_tot++; if (dat(2,0) !== 32'h12) $display("FAIL col_stage2 got %h exp 12", dat(2,0)); else n_pass++;
      n_tot++; if (valid_o !== 8'b11_11_00_11) $display("FAIL col_valid got %b exp 11110011", valid_o); else n_pass++;
      n_tot++; if (in_ready_o !== 1'b1) $display("FAIL col_ready1 got %b exp 1", in_ready_o); else n_pass++;
      in_data_i = {32'h17, 32'h16}; tick();
      n_tot++; if (in_ready_o !== 1'b0) $display("FAIL col_ready0 got %b exp 0", in_ready_o); else n_pass++;
      n_tot++; if (occupancy_o !== 4'd8) $display("FAIL col_occ got %0d exp 8", occupancy_o); else n_pass++;
      n_tot++; if (dat(1,0) !== 32'h14) $display("FAIL col_stage1 got %h exp 14", dat(1,0)); else n_pass++;
   endtask

   task automatic test_lane_hold();
      do_reset();
      in_valid_i = 2'b11; in_data_i = {32'hBB, 32'hAA}; tick();
      in_data_i = {32'hCD, 32'hCC}; lane_hold_i = 2'b01; #1;
      n_tot++; if (in_ready_o !== 1'b0) $display("FAIL lh_ready got %b exp 0", in_ready_o); else n_pass++;
      tick();
      n_tot++; if (vld(0) !== 2'b01) $display("FAIL lh_s0_valid got %b exp 01", vld(0)); else n_pass++;
      n_tot++; if (dat(0,0) !== 32'hAA) $display("FAIL lh_s0_lane0 got %h exp aa", dat(0,0)); else n_pass++;
      n_tot++; if (dat(0,1) !== 32'h0) $display("FAIL lh_s0_lane1 got %h exp 0", dat(0,1)); else n_pass++;
      n_tot++; if (vld(1) !== 2'b10) $display("FAIL lh_s1_valid got %b exp 10", vld(1)); else n_pass++;
      n_tot++; if (dat(1,1) !== 32'hBB) $display("FAIL lh_s1_lane1 got %h exp bb", dat(1,1)); else n_pass++;
      n_tot++; if (dat(1,0) !== 32'h0) $display("FAIL lh_s1_lane0 got %h exp 0", dat(1,0)); else n_pass++;
      lane_hold_i = 2'b10; #1;
      n_tot++; if (in_ready_o !== 1'b1) $display("FAIL lh_empty_lane got %b exp 1", in_ready_o); else n_pass++;
      lane_hold_i = 2'b00;
   endtask

   task automatic test_flush();
      do_reset();
      in_valid_i = 2'b11;
      for (int e = 1; e <= 4; e++) begin
         in_data_i = {32'(e*16+1), 32'(e*16)};
         tick();
      end
      flush_i = 1'b1; flush_stage_i = 2'd1; in_data_i = {32'h99, 32'h98}; #1;
      n_tot++; if (in_ready_o !== 1'b0) $display("FAIL fl_ready got %b exp 0", in_ready_o); else n_pass++;
      tick();
      n_tot++; if (valid_o[5:0] !== 6'b0) $display("FAIL fl_valid got %b exp 000000", valid_o[5:0]); else n_pass++;
      n_tot++; if (data_o[6*W-1:0] !== '0) $display("FAIL fl_data got nonzero exp 0"); else n_pass++;
      n_tot++; if (dat(3,0) !== 32'h20) $display("FAIL fl_s3 got %h exp 20", dat(3,0)); else n_pass++;
      n_tot++; if (occupancy_o !== 4'd2) $display("FAIL fl_occ got %0d exp 2", occupancy_o); else n_pass++;
      flush_stage_i = 2'd3; stage_stall_i = 4'b1111; tick();
      n_tot++; if (occupancy_o !== 4'd0) $display("FAIL fl_all_occ got %0d exp 0", occupancy_o); else n_pass++;
      flush_i = 1'b0; stage_stall_i = '0; in_valid_i = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid_i = 2'b11; in_data_i = {32'h31, 32'h30};
      repeat (3) tick();
      n_tot++; if (occupancy_o !== 4'd6) $display("FAIL rm_occ6 got %0d exp 6", occupancy_o); else n_pass++;
      #2 reset_i = 1'b1;
      #1;
      n_tot++; if (valid_o !== '0) $display("FAIL rm_valid got %h exp 0", valid_o); else n_pass++;
      n_tot++; if (occupancy_o !== 4'd0) $display("FAIL rm_occ got %0d exp 0", occupancy_o); else n_pass++;
      tick();
      reset_i = 1'b0; in_valid_i = 2'b11; in_data_i = {32'hE1, 32'hE0}; tick();
      in_valid_i = 2'b00;
      repeat (2) tick();
      n_tot++; if (vld(3) !== 2'b00) $display("FAIL rm_early got %b exp 00", vld(3)); else n_pass++;
      tick();
      n_tot++; if (vld(3) !== 2'b11) $display("FAIL rm_valid3 got %b exp 11", vld(3)); else n_pass++;
      n_tot++; if (dat(3,0) !== 32'hE0) $display("FAIL rm_data3 got %h exp e0", dat(3,0)); else n_pass++;
   endtask

   task automatic test_stall_cnt();
      do_reset();
      in_valid_i = 2'b01; in_data_i = {32'h0, 32'h55}; tick();
      stage_stall_i = 4'b0001;
      repeat (10) tick();
      n_tot++; if (stall_cnt_o !== 16'd10) $display("FAIL sc_ten got %0d exp 10", stall_cnt_o); else n_pass++;
      n_tot++; if (in_ready_o !== 1'b0) $display("FAIL sc_ready got %b exp 0", in_ready_o); else n_pass++;
      repeat (65525) tick();
      n_tot++; if (stall_cnt_o !== 16'hFFFF) $display("FAIL sc_sat got %h exp ffff", stall_cnt_o); else n_pass++;
      repeat (5) tick();
      n_tot++; if (stall_cnt_o !== 16'hFFFF) $display("FAIL sc_hold got %h exp ffff", stall_cnt_o); else n_pass++;
      stage_stall_i = '0; in_valid_i = '0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_collapse();
      test_lane_hold();
      test_flush();
      test_reset_mid();
      test_stall_cnt();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
